fp_mul_round_stage: RTL

- Downstream stage of the single-precision multiplier datapath.
- Consumes the raw product: sign, pre-normalisation biased exponent sum and full 48-bit significand product.
- Normalises, rounds to nearest-even and encodes an IEEE-754 binary32 result with exception flags.
- Two-stage valid/ready pipeline with full backpressure, so the combinational multiplier ahead of it is decoupled from the consumer.

---
 rtl/fp_mul_pkg.sv | 50 +++++
 rtl/fp_mul_round_stage_rne.sv | 28 ++
 rtl/fp_mul_round_stage.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/fp_mul_pkg.sv
// Shared widths, payload structs and the normalise helper for the binary32 multiplier round stage.
package fp_mul_pkg;
  localparam int EXP_W   = 10;
  localparam int MANT_W  = 48;
  localparam int SEXP_W  = EXP_W + 2;  // room for the normalise and rounding increments
  localparam int FRAC_W  = 23;
  localparam int BIAS    = 127;
  localparam int EXP_MAX = 255;

  typedef struct packed {
    logic                     sign;
    logic signed [EXP_W-1:0]  exp;
    logic [MANT_W-1:0]        mant;
    logic                     zero;
  } raw_prod_t;

  typedef struct packed {
    logic                     sign;
    logic signed [SEXP_W-1:0] exp;
    logic [23:0]              sig24;
    logic                     guard;
    logic                     sticky;
    logic                     zero;
  } norm_t;

  typedef struct packed {
    logic overflow;
    logic underflow;
    logic inexact;
  } fp_flags_t;

  // The product lies in [1,4); a set top bit means one extra binade.
  function automatic norm_t normalise(input raw_prod_t p);
    norm_t n;
    n.sign = p.sign;
    n.zero = p.zero;
    if (p.mant[MANT_W-1]) begin
      n.exp    = {{2{p.exp[EXP_W-1]}}, p.exp} + SEXP_W'(1);
      n.sig24  = p.mant[MANT_W-1 -: 24];
      n.guard  = p.mant[MANT_W-25];
      n.sticky = |p.mant[MANT_W-26:0];
    end else begin
      n.exp    = {{2{p.exp[EXP_W-1]}}, p.exp};
      n.sig24  = p.mant[MANT_W-2 -: 24];
      n.guard  = p.mant[MANT_W-26];
      n.sticky = |p.mant[MANT_W-27:0];
    end
    return n;
  endfunction
endpackage

// File: rtl/fp_mul_round_stage_rne.sv
// Combinational round-to-nearest-even of a 24-bit significand with exponent adjust.
module fp_round_rne
  import fp_mul_pkg::*;
(
  input  logic [23:0]              sig_in,
  input  logic                     guard,
  input  logic                     sticky,
  input  logic signed [SEXP_W-1:0] exp_in,
  output logic [FRAC_W-1:0]        frac_out,
  output logic signed [SEXP_W-1:0] exp_out,
  output logic                     inexact
);
  logic        round_up;
  logic [24:0] sum;

  always_comb begin
    round_up = guard & (sticky | sig_in[0]);
    sum      = {1'b0, sig_in} + {24'b0, round_up};
    inexact  = guard | sticky;
    frac_out = sum[FRAC_W-1:0];
    // A cleared hidden bit marks a subnormal, whose exponent field is zero.
    exp_out  = sum[23] ? exp_in : '0;
    if (sum[24]) begin
      frac_out = '0;
      exp_out  = exp_in + SEXP_W'(1);
    end
  end
endmodule

// File: rtl/fp_mul_round_stage.sv
// Two-stage normalise / round / encode pipeline for binary32 products.
// Define FP_MUL_DENORM_EN to produce subnormal results instead of flushing tiny results to zero.
module fp_mul_round_stage
  import fp_mul_pkg::*;
#(
  parameter int EXP_W  = fp_mul_pkg::EXP_W,
  parameter int MANT_W = fp_mul_pkg::MANT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic [MANT_W-1:0] in_mant,
  input  logic              in_zero,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_result,
  output logic              out_overflow,
  output logic              out_underflow,
  output logic              out_inexact
);
  // Handshake: a word moves across a boundary on the cycle its valid and ready are both high;
  // a stage may load when it is empty or is handing its own word on in the same cycle, so a
  // full pipe with a ready consumer accepts a new product every cycle without a bubble.

  raw_prod_t raw;
  norm_t     s1_q;
  logic      s1_valid;
  logic      s1_advance;
  fp_flags_t flags_q;
  fp_flags_t flags_d;
  logic [31:0] result_d;

  assign raw        = '{sign: in_sign, exp: in_exp, mant: in_mant, zero: in_zero};
  assign s1_advance = s1_valid && (!out_valid || out_ready);
  assign in_ready   = !s1_valid || s1_advance;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else if (in_valid && in_ready) begin
      s1_valid <= 1'b1;
      s1_q     <= normalise(raw);
    end else if (s1_advance) begin
      s1_valid <= 1'b0;
    end
  end

  logic signed [SEXP_W-1:0] s1_exp;
  logic                     tiny;
  logic [23:0]              r_sig;
  logic                     r_guard;
  logic                     r_sticky;
  logic signed [SEXP_W-1:0] r_exp;
`ifdef FP_MUL_DENORM_EN
  logic [4:0]               sh;
  logic [49:0]              wide;
`endif

  always_comb begin
    s1_exp = s1_q.exp;
    tiny   = (s1_exp <= 0);
`ifdef FP_MUL_DENORM_EN
    // Denormalise tiny values; 25 places already pushes every significand bit into sticky.
    if (!tiny)
      sh = '0;
    else if (s1_exp < -24)
      sh = 5'd25;
    else
      sh = 5'(SEXP_W'(1) - s1_exp);
    wide     = {s1_q.sig24, s1_q.guard, 25'b0} >> sh;
    r_sig    = wide[49:26];
    r_guard  = wide[25];
    r_sticky = s1_q.sticky | (|wide[24:0]);
    r_exp    = tiny ? SEXP_W'(1) : s1_exp;
`else
    r_sig    = s1_q.sig24;
    r_guard  = s1_q.guard;
    r_sticky = s1_q.sticky;
    r_exp    = s1_exp;
`endif
  end

  logic [FRAC_W-1:0]        rnd_frac;
  logic signed [SEXP_W-1:0] rnd_exp;
  logic                     rnd_inexact;

  fp_round_rne u_round (
    .sig_in   (r_sig),
    .guard    (r_guard),
    .sticky   (r_sticky),
    .exp_in   (r_exp),
    .frac_out (rnd_frac),
    .exp_out  (rnd_exp),
    .inexact  (rnd_inexact)
  );

  // Overflow looks at the rounded exponent; tininess is judged before rounding.
  always_comb begin
    result_d = '0;
    flags_d  = '0;
    if (s1_q.zero) begin
      result_d = {s1_q.sign, 31'b0};
    end else if (rnd_exp >= EXP_MAX) begin
      result_d         = {s1_q.sign, 8'hFF, 23'b0};
      flags_d.overflow = 1'b1;
      flags_d.inexact  = 1'b1;
    end else if (tiny) begin
`ifdef FP_MUL_DENORM_EN
      result_d          = {s1_q.sign, rnd_exp[7:0], rnd_frac};
      flags_d.underflow = rnd_inexact;
      flags_d.inexact   = rnd_inexact;
`else
      result_d          = {s1_q.sign, 31'b0};
      flags_d.underflow = 1'b1;
      flags_d.inexact   = 1'b1;
`endif
    end else begin
      result_d        = {s1_q.sign, rnd_exp[7:0], rnd_frac};
      flags_d.inexact = rnd_inexact;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      flags_q    <= '0;
    end else if (s1_advance) begin
      out_valid  <= 1'b1;
      out_result <= result_d;
      flags_q    <= flags_d;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

  assign out_overflow  = flags_q.overflow;
  assign out_underflow = flags_q.underflow;
  assign out_inexact   = flags_q.inexact;
endmodule
